// File: rtl/array_pkg.sv
// Shared definitions for the systolic-array front end: FSM encoding, default
// geometry and the wave-counter width helper.
package array_pkg;

  localparam int unsigned W_DEF = 8;
  localparam int unsigned N_DEF = 4;
  localparam int unsigned K_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // The wave counter runs 0..k+n-2, which always fits in clog2(k+n) bits.
  function automatic int unsigned wave_w(input int unsigned k, input int unsigned n);
    return $clog2(k + n);
  endfunction

endpackage

// File: rtl/skew_window_decode.sv
// Decodes the wave counter into the set of rows whose K-word read window is open:
// row i is active for i <= c <= i+K-1.
module skew_window_decode #(
  parameter int unsigned N  = 4,
  parameter int unsigned K  = 4,
  parameter int unsigned CW = 3
) (
  input  logic [CW-1:0] c,
  output logic [N-1:0]  active
);

  for (genvar i = 0; i < N; i++) begin : g_row
    localparam logic [CW-1:0] LO = CW'(i);
    localparam logic [CW-1:0] HI = CW'(i + K - 1);
    // Row 0's lower bound is trivially met, so only the upper bound is compared.
    if (i == 0) begin : g_first
      assign active[i] = (c <= HI);
    end else begin : g_rest
      assign active[i] = (c >= LO) && (c <= HI);
    end
  end

endmodule

// File: rtl/array_skew_feeder.sv
// Drains the per-row alignment FIFOs with a one-cycle-per-row stagger so the
// systolic array sees a diagonal wavefront; stalls freeze every row together.
module array_skew_feeder
  import array_pkg::*;
#(
  parameter int unsigned W = W_DEF,
  parameter int unsigned N = N_DEF,
  parameter int unsigned K = K_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [N-1:0]     fifo_empty,
  input  logic [N*W-1:0]   fifo_data,
  output logic [N-1:0]     fifo_re,
  output logic [N*W-1:0]   row_data,
  output logic [N-1:0]     row_valid,
  output logic             busy,
  output logic             done,
  output logic [15:0]      stall_cnt
);

  localparam int unsigned   CW      = wave_w(K, N);
  localparam logic [CW-1:0] C_LAST  = CW'(K + N - 2);
  localparam logic [15:0]   CNT_MAX = 16'hFFFF;

  state_t        state, state_nx;
  logic [CW-1:0] c, c_nx;
  logic [N-1:0]  active;
  logic          stall;
  logic          busy_nx;
  logic          done_nx;

  skew_window_decode #(
    .N  (N),
    .K  (K),
    .CW (CW)
  ) u_decode (
    .c      (c),
    .active (active)
  );

  // State, wave counter and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      c         <= '0;
      row_valid <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nx;
      c         <= c_nx;
      row_valid <= fifo_re;
      busy      <= busy_nx;
      done      <= done_nx;
      if (stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  // Next state, wave advance and read enables; any empty active row stalls the whole wave.
  always_comb begin
    state_nx = state;
    c_nx     = c;
    fifo_re  = '0;
    stall    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_STREAM;
          c_nx     = '0;
        end
      end
      ST_STREAM: begin
        stall = |(active & fifo_empty);
        if (!stall) begin
          fifo_re = active;
          if (c == C_LAST) begin
            state_nx = ST_FLUSH;
          end else begin
            c_nx = c + CW'(1);
          end
        end
      end
      ST_FLUSH: begin
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
        c_nx     = '0;
      end
      default: begin
        state_nx = ST_IDLE;
        c_nx     = '0;
      end
    endcase
    busy_nx = (state_nx == ST_STREAM) || (state_nx == ST_FLUSH);
    done_nx = (state_nx == ST_DONE);
  end

  // FIFO output is only meaningful the cycle after a read; mask it otherwise.
  always_comb begin
    row_data = '0;
    for (int i = 0; i < N; i++) begin
      row_data[i*W +: W] = row_valid[i] ? fifo_data[i*W +: W] : W'(0);
    end
  end

endmodule
